// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM request-port arbiter.
package dram_arb_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_GAP  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  typedef logic [1:0] src_t;
  localparam src_t SRC_LD = 2'd0;
  localparam src_t SRC_ST = 2'd1;
  localparam src_t SRC_RF = 2'd2;

endpackage

// File: rtl/dram_arb_if.sv
// Requester, refill and DRAM-controller signals of the arbiter, grouped as one bundle.
interface dram_arb_if
  import dram_arb_pkg::*;
#(
  parameter int unsigned AW = 32
);
  logic              ld_we;
  logic [AW-1:0]     ld_addr;
  logic [WORD_W-1:0] ld_wdata;
  logic              ld_ovf;

  logic              st_valid;
  logic              st_ready;
  logic [AW-1:0]     st_addr;
  logic [WORD_W-1:0] st_wdata;
  logic [3:0]        st_we;

  logic              rf_valid;
  logic              rf_ready;
  logic [AW-1:0]     rf_addr;
  logic              rf_done;
  logic [WORD_W-1:0] rf_rdata;
  logic [AW-1:0]     rf_done_addr;

  logic              dram_oe;
  logic [AW-1:0]     dram_addr;
  logic [WORD_W-1:0] dram_wdata;
  logic [3:0]        dram_we;
  logic              dram_busy;
  logic              dram_valid;
  logic [WORD_W-1:0] dram_rdata;

  logic              idle;

  modport slave (
    input  ld_we, ld_addr, ld_wdata, st_valid, st_addr, st_wdata, st_we,
           rf_valid, rf_addr, dram_busy, dram_valid, dram_rdata,
    output ld_ovf, st_ready, rf_ready, rf_done, rf_rdata, rf_done_addr,
           dram_oe, dram_addr, dram_wdata, dram_we, idle
  );

  modport master (
    output ld_we, ld_addr, ld_wdata, st_valid, st_addr, st_wdata, st_we,
           rf_valid, rf_addr, dram_busy, dram_valid, dram_rdata,
    input  ld_ovf, st_ready, rf_ready, rf_done, rf_rdata, rf_done_addr,
           dram_oe, dram_addr, dram_wdata, dram_we, idle
  );
endinterface

// File: rtl/dram_wfifo.sv
// Synchronous store FIFO; pointers carry one extra wrap bit to tell full from empty.
module dram_wfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 68
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  input  logic                   pop,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign dout    = mem[rptr[PW-2:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only read behind a valid pointer.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[PW-2:0]] <= din;
  end
endmodule

// File: rtl/dram_arb.sv
// Arbitrates loader writes, buffered stores and refill reads onto one DRAM port,
// holding refills back until every older write has been issued.
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 32
) (
  input  logic       CLK,
  input  logic       RST_X,
  dram_arb_if.slave  bus
);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FDW = AW + WORD_W + 4;

  state_t            state, state_nxt;
  logic              ld_pend, ld_pend_nxt, ld_ovf_q;
  logic [AW-1:0]     ld_addr_q, rf_addr_q;
  logic [WORD_W-1:0] ld_data_q;

  logic              oe_q, rf_ready_q, rf_done_q, idle_q;
  logic [AW-1:0]     addr_q, done_addr_q;
  logic [WORD_W-1:0] wdata_q, rdata_q;
  logic [3:0]        we_q;

  logic              full, empty, st_fire, rf_elig, issue, pop, idle_nxt;
  logic [PW-1:0]     count, cnt_nxt;
  logic [FDW-1:0]    head;
  logic [AW-1:0]     h_addr;
  logic [WORD_W-1:0] h_wdata;
  logic [3:0]        h_we;
  src_t              src;

  dram_wfifo #(.DEPTH(FIFO_DEPTH), .DW(FDW)) u_wfifo (
    .CLK   (CLK),
    .RST_X (RST_X),
    .push  (st_fire),
    .din   ({bus.st_addr, bus.st_wdata, bus.st_we}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign {h_addr, h_wdata, h_we} = head;
  assign st_fire = bus.st_valid && !full;
  // A write arriving this cycle (store or loader) must still land ahead of the refill.
  assign rf_elig = bus.rf_valid && empty && !ld_pend && !bus.ld_we && !st_fire;

  // Issue decision and next-state values.
  always_comb begin
    issue     = 1'b0;
    src       = SRC_LD;
    state_nxt = state;
    if (state == IDLE && !bus.dram_busy) begin
      if (ld_pend) begin
        issue = 1'b1;
        src   = SRC_LD;
      end else if (!empty) begin
        issue = 1'b1;
        src   = SRC_ST;
      end else if (rf_elig) begin
        issue = 1'b1;
        src   = SRC_RF;
      end
    end
    case (state)
      IDLE:    if (issue) state_nxt = (src == SRC_RF) ? RD_WAIT : WR_GAP;
      WR_GAP:  state_nxt = IDLE;
      RD_WAIT: if (bus.dram_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    pop         = issue && (src == SRC_ST);
    ld_pend_nxt = bus.ld_we || (ld_pend && !(issue && src == SRC_LD));
    cnt_nxt     = count + PW'(st_fire) - PW'(pop);
    idle_nxt    = (cnt_nxt == '0) && !ld_pend_nxt && (state_nxt == IDLE);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state       <= IDLE;
      ld_pend     <= 1'b0;
      ld_ovf_q    <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      rf_addr_q   <= '0;
      oe_q        <= 1'b0;
      rf_ready_q  <= 1'b0;
      rf_done_q   <= 1'b0;
      idle_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= '0;
      rdata_q     <= '0;
      done_addr_q <= '0;
    end else begin
      state      <= state_nxt;
      ld_pend    <= ld_pend_nxt;
      idle_q     <= idle_nxt;
      oe_q       <= issue;
      rf_ready_q <= issue && (src == SRC_RF);
      rf_done_q  <= (state == RD_WAIT) && bus.dram_valid;
      if (bus.ld_we) begin
        ld_addr_q <= bus.ld_addr;
        ld_data_q <= bus.ld_wdata;
        if (ld_pend) ld_ovf_q <= 1'b1;
      end
      if (issue) begin
        case (src)
          SRC_LD: begin
            addr_q  <= ld_addr_q;
            wdata_q <= ld_data_q;
            we_q    <= 4'hf;
          end
          SRC_ST: begin
            addr_q  <= h_addr;
            wdata_q <= h_wdata;
            we_q    <= h_we;
          end
          default: begin
            addr_q    <= bus.rf_addr;
            we_q      <= 4'h0;
            rf_addr_q <= bus.rf_addr;
          end
        endcase
      end
      if (state == RD_WAIT && bus.dram_valid) begin
        rdata_q     <= bus.dram_rdata;
        done_addr_q <= rf_addr_q;
      end
    end
  end

  assign bus.ld_ovf       = ld_ovf_q;
  assign bus.st_ready     = !full;
  assign bus.rf_ready     = rf_ready_q;
  assign bus.rf_done      = rf_done_q;
  assign bus.rf_rdata     = rdata_q;
  assign bus.rf_done_addr = done_addr_q;
  assign bus.dram_oe      = oe_q;
  assign bus.dram_addr    = addr_q;
  assign bus.dram_wdata   = wdata_q;
  assign bus.dram_we      = we_q;
  assign bus.idle         = idle_q;
endmodule

// File: tb/tb_dram_arb.sv
// Directed bench for dram_arb: DRAM requests and refill results checked against queued expectations.
module tb_dram_arb;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    bit          rd;
  } tx_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } rf_t;

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   oe_cnt = 0;
  int   rf_ready_cnt = 0;
  int   rf_done_cnt = 0;
  int   oe_cyc[$];
  tx_t  exp_q[$];
  rf_t  rf_q[$];

  dram_arb_if #(.AW(32)) bus ();

  dram_arb #(.FIFO_DEPTH(4), .AW(32)) dut (
    .CLK   (clk),
    .RST_X (rst_x),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DRAM-side and refill-side monitor, sampled mid-cycle.
  always @(negedge clk) begin
    tx_t e;
    rf_t r;
    if (bus.rf_ready) rf_ready_cnt++;
    if (bus.dram_oe) begin
      oe_cnt++;
      oe_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_oe", 64'(bus.dram_addr), 64'hffff_ffff_ffff);
      else begin
        e = exp_q.pop_front();
        chk("oe_addr", 64'(bus.dram_addr), 64'(e.addr));
        chk("oe_we", 64'(bus.dram_we), 64'(e.we));
        if (!e.rd) chk("oe_wdata", 64'(bus.dram_wdata), 64'(e.wdata));
      end
    end
    if (bus.rf_done) begin
      rf_done_cnt++;
      if (rf_q.size() == 0) chk("unexpected_rf_done", 64'(bus.rf_done_addr), 64'hffff_ffff_ffff);
      else begin
        r = rf_q.pop_front();
        chk("rf_rdata", 64'(bus.rf_rdata), 64'(r.data));
        chk("rf_done_addr", 64'(bus.rf_done_addr), 64'(r.addr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                          output int acc);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_wdata = d;
    bus.st_we    = w;
    exp_q.push_back('{a, d, w, 1'b0});
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      if (bus.st_ready) begin
        acc = cyc;
        step();
        break;
      end
      step();
    end
    bus.st_valid = 1'b0;
    chk("store_accept_timeout", 64'(acc >= 0), 64'd1);
  endtask

  task automatic wait_oe(input int target, input string tag);
    for (int i = 0; i < 60; i++) begin
      if (oe_cnt >= target) break;
      step();
    end
    chk(tag, 64'(oe_cnt >= target), 64'd1);
  endtask

  task automatic wait_rf_ready(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.rf_ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("rf_ready_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    int acc;
    int base;
    int fall;
    int rdy0;
    bit got;

    bus.ld_we = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
    bus.st_valid = 0; bus.st_addr = 0; bus.st_wdata = 0; bus.st_we = 0;
    bus.rf_valid = 0; bus.rf_addr = 0;
    bus.dram_busy = 0; bus.dram_valid = 0; bus.dram_rdata = 0;

    // Reset values
    repeat (3) step();
    chk("rst_st_ready", 64'(bus.st_ready), 64'd1);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_dram_oe", 64'(bus.dram_oe), 64'd0);
    chk("rst_ld_ovf", 64'(bus.ld_ovf), 64'd0);
    chk("rst_rf_done", 64'(bus.rf_done), 64'd0);
    chk("rst_dram_addr", 64'(bus.dram_addr), 64'd0);
    chk("rst_dram_we", 64'(bus.dram_we), 64'd0);
    chk("rst_rf_rdata", 64'(bus.rf_rdata), 64'd0);
    rst_x = 1'b1;
    step();
    chk("post_rst_idle", 64'(bus.idle), 64'd1);

    // FIFO fill while busy, then drain
    bus.dram_busy = 1'b1;
    base = oe_cnt;
    for (int i = 0; i < 4; i++)
      do_store(32'h100 + 32'(4 * i), 32'(i + 1), 4'(i + 1), acc);
    chk("full_st_ready", 64'(bus.st_ready), 64'd0);
    chk("full_idle", 64'(bus.idle), 64'd0);
    chk("busy_no_oe_fill", 64'(oe_cnt), 64'(base));
    bus.dram_busy = 1'b0;
    do_store(32'h110, 32'd5, 4'hc, acc);
    wait_oe(base + 5, "drain_timeout");
    for (int i = 1; i < 5; i++)
      chk("drain_spacing", 64'(oe_cyc[base + i] - oe_cyc[base + i - 1]), 64'd2);
    step();
    step();
    chk("drain_idle", 64'(bus.idle), 64'd1);

    // Store latency from an empty FIFO
    base = oe_cnt;
    do_store(32'h120, 32'h55aa_1234, 4'h3, acc);
    wait_oe(base + 1, "latency_timeout");
    chk("store_latency", 64'(oe_cyc[base] - acc), 64'd2);

    // Busy stall
    step();
    bus.dram_busy = 1'b1;
    do_store(32'h300, 32'h3333_0000, 4'hf, acc);
    base = oe_cnt;
    repeat (10) step();
    chk("busy_stall_no_oe", 64'(oe_cnt), 64'(base));
    bus.dram_busy = 1'b0;
    fall = cyc;
    wait_oe(base + 1, "stall_timeout");
    chk("stall_release_lat", 64'(oe_cyc[base] - fall), 64'd1);
    step();
    step();

    // Refill ordering behind two stores
    bus.dram_busy = 1'b1;
    do_store(32'h180, 32'hA0A0_0001, 4'hf, acc);
    do_store(32'h184, 32'hA0A0_0002, 4'h1, acc);
    base = oe_cnt;
    rdy0 = rf_ready_cnt;
    bus.rf_valid = 1'b1;
    bus.rf_addr  = 32'h200;
    exp_q.push_back('{32'h200, 32'h0, 4'h0, 1'b1});
    step();
    bus.dram_busy = 1'b0;
    wait_rf_ready(got);
    chk("rf_after_writes", 64'(oe_cnt), 64'(base + 2));
    chk("rf_ready_with_oe", 64'(bus.dram_oe), 64'd1);
    step();
    bus.rf_valid = 1'b0;
    chk("rf_ready_pulse", 64'(bus.rf_ready), 64'd0);
    step();
    bus.dram_valid = 1'b1;
    bus.dram_rdata = 32'hDEAD_BEEF;
    rf_q.push_back('{32'h200, 32'hDEAD_BEEF});
    step();
    bus.dram_valid = 1'b0;
    chk("rf_done_lat", 64'(bus.rf_done), 64'd1);
    step();
    chk("rf_done_one_cycle", 64'(bus.rf_done), 64'd0);
    chk("rf_ready_count", 64'(rf_ready_cnt - rdy0), 64'd1);
    chk("rf_idle", 64'(bus.idle), 64'd1);

    // Stray return in IDLE
    base = rf_done_cnt;
    bus.dram_valid = 1'b1;
    bus.dram_rdata = 32'h0BAD_0BAD;
    step();
    bus.dram_valid = 1'b0;
    step();
    step();
    chk("stray_no_done", 64'(rf_done_cnt), 64'(base));

    // Loader overflow while busy
    bus.dram_busy = 1'b1;
    bus.ld_we = 1'b1; bus.ld_addr = 32'h400; bus.ld_wdata = 32'hAAAA_0000;
    step();
    bus.ld_we = 1'b0;
    chk("ld_ovf_single", 64'(bus.ld_ovf), 64'd0);
    chk("ld_pending_idle", 64'(bus.idle), 64'd0);
    step();
    bus.ld_we = 1'b1; bus.ld_addr = 32'h404; bus.ld_wdata = 32'hBBBB_1111;
    exp_q.push_back('{32'h404, 32'hBBBB_1111, 4'hf, 1'b0});
    step();
    bus.ld_we = 1'b0;
    chk("ld_ovf_set", 64'(bus.ld_ovf), 64'd1);
    base = oe_cnt;
    bus.dram_busy = 1'b0;
    repeat (8) step();
    chk("ld_single_issue", 64'(oe_cnt), 64'(base + 1));
    chk("ld_ovf_sticky", 64'(bus.ld_ovf), 64'd1);
    chk("ld_idle", 64'(bus.idle), 64'd1);

    // Reset in the middle of a read
    base = rf_done_cnt;
    bus.rf_valid = 1'b1;
    bus.rf_addr  = 32'h500;
    exp_q.push_back('{32'h500, 32'h0, 4'h0, 1'b1});
    wait_rf_ready(got);
    step();
    bus.rf_valid = 1'b0;
    chk("rd_wait_not_idle", 64'(bus.idle), 64'd0);
    rst_x = 1'b0;
    step();
    step();
    rst_x = 1'b1;
    step();
    bus.dram_valid = 1'b1;
    bus.dram_rdata = 32'h1234_5678;
    step();
    bus.dram_valid = 1'b0;
    step();
    step();
    chk("rst_read_no_done", 64'(rf_done_cnt), 64'(base));
    chk("rst_read_rf_done", 64'(bus.rf_done), 64'd0);
    chk("rst_read_idle", 64'(bus.idle), 64'd1);
    chk("rst_read_ld_ovf", 64'(bus.ld_ovf), 64'd0);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("rf_q_empty", 64'(rf_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
